inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-issue stage directly upstream of the pipelined CPU; drives the CPU's 32-bit `inst` input once per clock.
- Holds a small program memory loaded before a run and walks a PC through it.
- Inserts no-op bubbles automatically on read-after-write hazards, replacing hand-placed no-ops in bench stimulus.
- Drains the pipeline with no-ops at end of program, then flags completion.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit program words.
- ADDR_W, 5, PC/address width; IMEM_DEPTH <= 2**ADDR_W.
- NOP_GAP, 1, issue slots (1..3) that must separate a writer of Rd from a reader of Rd.
- DRAIN_CYCLES, 4, no-ops issued after the last program instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- load_en  in  1  write load_data to imem[load_addr]; honoured only in IDLE.
- load_addr  in  ADDR_W  program write address.
- load_data  in  32  program word.
- prog_len  in  ADDR_W+1  instruction count; sampled when start is accepted.
- start  in  1  begin run; honoured only in IDLE or DONE.
- inst  out  32  instruction to the CPU, registered.
- inst_valid  out  1  inst is an issue slot (RUN/DRAIN).
- bubble  out  1  current inst is an inserted or drain no-op.
- pc  out  ADDR_W  address of the next candidate instruction.
- stall_cnt  out  8  hazard bubbles inserted this run; saturates at 255.
- done  out  1  program issued and drained.

Behaviour:
- Reset is synchronous, active-low: one clock, rst is the synchronous active-low reset.
  - Outputs on reset: inst=NOP (32'h00000020), inst_valid=0, bubble=0, pc=0, stall_cnt=0, done=0, state=IDLE, hazard history cleared to 0.
  - imem contents are not reset.
  - rst low in any state, including mid-RUN or mid-DRAIN, returns to IDLE next edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - inst=NOP, inst_valid=0.
  - load_en writes imem; load_en in any other state is ignored.
  - start with prog_len!=0 -> RUN; pc=0, stall_cnt=0, history cleared, done=0.
  - start with prog_len==0 -> DONE directly.
- RUN, each edge, with cand = imem[pc]:
  - Hazard = cand[31:26]==0 and (cand rs or cand rt) equals any nonzero entry in the NOP_GAP-deep destination history.
  - On hazard:
    - inst<=NOP, bubble<=1, pc held, stall_cnt++ (saturating).
    - history shifts in 0.
  - Otherwise:
    - inst<=cand, bubble<=0, pc<=pc+1.
    - history shifts in cand rd if R-type, else 0.
  - Register 0 is never a hazard source.
  - Non-R-type words issue unchecked.
  - inst_valid=1 throughout RUN.
- Latency: start sampled at edge N -> RUN; imem[0] appears on inst after edge N+1 unless hazard.
- RUN -> DRAIN on the edge that issues the instruction at pc==prog_len-1.
  - That instruction is on inst in the first DRAIN cycle.
  - prog_len > IMEM_DEPTH is clamped to IMEM_DEPTH.
- DRAIN:
  - DRAIN_CYCLES slots of inst=NOP, bubble=1, inst_valid=1.
  - Drain no-ops do not increment stall_cnt.
  - Then -> DONE.
- DONE:
  - done=1, inst=NOP, inst_valid=0, bubble=0.
  - stall_cnt and pc held for readout.
  - start restarts exactly as from IDLE; load_en is ignored until reset.
- pc never wraps; it stops at prog_len.

Optional Feature:
- Macro: FETCH_HAZARD_DETECT_EN.
- Defined: bubble insertion on hazards as above.
- Undefined:
  - Hazard logic and history are removed; every cycle in RUN issues imem[pc] and increments pc.
  - bubble is asserted only during DRAIN.
  - stall_cnt stays 0.
  - This configuration is for a CPU with forwarding.

Test Plan:
- Dependent chain, NOP_GAP=1, macro defined:
  - Stimulus: load 00430820, 00262022, 00243824, 00E75025, 0144802A; prog_len=5; start.
  - inst sequence: 00430820, NOP, 00262022, NOP, 00243824, NOP, 00E75025, NOP, 0144802A, then 4 NOPs.
  - Then done=1, stall_cnt=4, pc=5.
- Independent program 00430820, 00A63822, 0109502A, prog_len=3 -> three back-to-back issues, bubble=0 each, stall_cnt=0, done after 3+4 slots.
- NOP_GAP=2 with 00430820 then 00262022 -> two NOPs between them, stall_cnt=2.
- Reset mid-RUN: rst=0 on the 3rd RUN cycle of the chain test.
  - Next edge: inst=NOP, inst_valid=0, pc=0, stall_cnt=0.
  - Restart reissues from 00430820 with imem intact.
- Boundaries:
  - start with prog_len=0 -> done=1 next cycle, inst_valid never 1.
  - load_en during RUN leaves imem unchanged; verify by reread on the next run.
- Macro undefined, dependent-chain program -> five consecutive issues with no NOPs, stall_cnt=0.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inst_fetch_unit_if : program-load / issue bus of the fetch unit       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 5
) ();
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [31:0]       load_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              bubble;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        stall_cnt;
  logic              done;

  modport master (
    output load_en, load_addr, load_data, prog_len, start,
    input  inst, inst_valid, bubble, pc, stall_cnt, done
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start,
    output inst, inst_valid, bubble, pc, stall_cnt, done
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inst_fetch_unit : program memory + PC walker feeding a pipelined CPU, |
// | with RAW bubble insertion (FETCH_HAZARD_DETECT_EN) and end drain.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module inst_fetch_unit #(
  parameter int IMEM_DEPTH   = 32,
  parameter int ADDR_W       = 5,
  parameter int NOP_GAP      = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input wire               clk,
  input wire               rst,
  inst_fetch_unit_if.slave bus
);

  localparam logic [31:0]   c_nop   = 32'h00000020;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(IMEM_DEPTH);
  localparam int            c_dw    = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_dw-1:0] c_drain_last = c_dw'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_inst, w_inst_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_bubble, w_bubble_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [7:0]        r_stall, w_stall_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic [c_dw-1:0]   r_drain, w_drain_nxt;
  logic [31:0]       r_imem [IMEM_DEPTH];
  logic [31:0]       w_cand;
  logic              w_hazard;
  logic              w_start_ok;

  assign w_cand     = r_imem[r_pc];
  assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef FETCH_HAZARD_DETECT_EN
  // r_hist[0] holds the Rd of the most recent issue slot (0 for bubbles / non-R-type)
  logic [4:0] r_hist [NOP_GAP];
  logic [4:0] w_hist_in;

  always_comb begin
    w_hazard = 1'b0;
    if (w_cand[31:26] == 6'd0) begin
      for (int i = 0; i < NOP_GAP; i++) begin
        if (r_hist[i] != 5'd0 &&
            (r_hist[i] == w_cand[25:21] || r_hist[i] == w_cand[20:16]))
          w_hazard = 1'b1;
      end
    end
  end

  assign w_hist_in = (!w_hazard && w_cand[31:26] == 6'd0) ? w_cand[15:11] : 5'd0;

  always_ff @(posedge clk) begin
    if (!rst || w_start_ok) begin
      for (int i = 0; i < NOP_GAP; i++) r_hist[i] <= 5'd0;
    end else if (r_state == S_RUN) begin
      r_hist[0] <= w_hist_in;
      for (int i = 1; i < NOP_GAP; i++) r_hist[i] <= r_hist[i-1];
    end
  end
`else
  logic w_unused_gap;
  assign w_unused_gap = (NOP_GAP > 0);
  assign w_hazard     = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_inst_nxt   = c_nop;
    w_valid_nxt  = 1'b0;
    w_bubble_nxt = 1'b0;
    w_done_nxt   = r_done;
    w_pc_nxt     = r_pc;
    w_stall_nxt  = r_stall;
    w_len_nxt    = r_len;
    w_drain_nxt  = r_drain;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_pc_nxt    = '0;
          w_stall_nxt = 8'd0;
          w_drain_nxt = '0;
          w_len_nxt   = (bus.prog_len > c_depth) ? c_depth : bus.prog_len;
          if (bus.prog_len == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_done_nxt  = 1'b0;
          end
        end
      end
      S_RUN: begin
        w_valid_nxt = 1'b1;
        if (w_hazard) begin
          w_bubble_nxt = 1'b1;
          if (r_stall != 8'hFF) w_stall_nxt = r_stall + 8'd1;
        end else begin
          w_inst_nxt = w_cand;
          if (r_pc != '1) w_pc_nxt = r_pc + 1'b1;
          if ({1'b0, r_pc} == r_len - 1'b1) begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = '0;
          end
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle still shows the last program word; then the no-ops
        if (r_drain == c_drain_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_valid_nxt  = 1'b1;
          w_bubble_nxt = 1'b1;
          w_drain_nxt  = r_drain + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_inst   <= c_nop;
      r_valid  <= 1'b0;
      r_bubble <= 1'b0;
      r_done   <= 1'b0;
      r_pc     <= '0;
      r_stall  <= 8'd0;
      r_len    <= '0;
      r_drain  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_inst   <= w_inst_nxt;
      r_valid  <= w_valid_nxt;
      r_bubble <= w_bubble_nxt;
      r_done   <= w_done_nxt;
      r_pc     <= w_pc_nxt;
      r_stall  <= w_stall_nxt;
      r_len    <= w_len_nxt;
      r_drain  <= w_drain_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.load_en && r_state == S_IDLE && {1'b0, bus.load_addr} < c_depth)
      r_imem[bus.load_addr] <= bus.load_data;
  end

  assign bus.inst       = r_inst;
  assign bus.inst_valid = r_valid;
  assign bus.bubble     = r_bubble;
  assign bus.pc         = r_pc;
  assign bus.stall_cnt  = r_stall;
  assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// Scoreboard bench for inst_fetch_unit: expected issue slots are queued by the
// stimulus and popped by per-DUT monitors; a NOP_GAP=2 instance runs alongside.
module tb_inst_fetch_unit;
  localparam int          ADDR_W = 5;
  localparam logic [31:0] NOP    = 32'h00000020;
`ifdef FETCH_HAZARD_DETECT_EN
  localparam int CHAIN_STALL = 4;
  localparam int CHAIN_CYC   = 14;
  localparam int GAP2_STALL  = 2;
`else
  localparam int CHAIN_STALL = 0;
  localparam int CHAIN_CYC   = 10;
  localparam int GAP2_STALL  = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(ADDR_W)) bus0 ();
  inst_fetch_unit_if #(.ADDR_W(ADDR_W)) bus1 ();

  inst_fetch_unit #(.IMEM_DEPTH(32), .ADDR_W(ADDR_W), .NOP_GAP(1), .DRAIN_CYCLES(4))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  inst_fetch_unit #(.IMEM_DEPTH(32), .ADDR_W(ADDR_W), .NOP_GAP(2), .DRAIN_CYCLES(4))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct packed { logic [31:0] inst; logic bubble; } slot_t;
  slot_t q0[$];
  slot_t q1[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    slot_t e;
    if (bus0.inst_valid === 1'b1) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_errors++;
        $display("FAIL slot0: unexpected inst=%h bubble=%0b, no slot required", bus0.inst, bus0.bubble);
      end else begin
        e = q0.pop_front();
        if (bus0.inst !== e.inst || bus0.bubble !== e.bubble) begin
          n_errors++;
          $display("FAIL slot0: got inst=%h bubble=%0b, required inst=%h bubble=%0b",
                   bus0.inst, bus0.bubble, e.inst, e.bubble);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    slot_t e;
    if (bus1.inst_valid === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL slot1: unexpected inst=%h bubble=%0b, no slot required", bus1.inst, bus1.bubble);
      end else begin
        e = q1.pop_front();
        if (bus1.inst !== e.inst || bus1.bubble !== e.bubble) begin
          n_errors++;
          $display("FAIL slot1: got inst=%h bubble=%0b, required inst=%h bubble=%0b",
                   bus1.inst, bus1.bubble, e.inst, e.bubble);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [31:0] i, input logic b);
    if (sel == 0) q0.push_back({i, b});
    else          q1.push_back({i, b});
  endtask

  task automatic push_chain();
`ifdef FETCH_HAZARD_DETECT_EN
    push(0, 32'h00430820, 1'b0); push(0, NOP, 1'b1);
    push(0, 32'h00262022, 1'b0); push(0, NOP, 1'b1);
    push(0, 32'h00243824, 1'b0); push(0, NOP, 1'b1);
    push(0, 32'h00E75025, 1'b0); push(0, NOP, 1'b1);
    push(0, 32'h0144802A, 1'b0);
`else
    push(0, 32'h00430820, 1'b0); push(0, 32'h00262022, 1'b0);
    push(0, 32'h00243824, 1'b0); push(0, 32'h00E75025, 1'b0);
    push(0, 32'h0144802A, 1'b0);
`endif
    repeat (4) push(0, NOP, 1'b1);
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus0.load_en = 1'b1; bus0.load_addr = a; bus0.load_data = d;
    bus1.load_en = 1'b1; bus1.load_addr = a; bus1.load_data = d;
    tick();
    bus0.load_en = 1'b0;
    bus1.load_en = 1'b0;
  endtask

  task automatic start_run(input int sel, input logic [ADDR_W:0] len);
    if (sel == 0) begin bus0.prog_len = len; bus0.start = 1'b1; end
    else          begin bus1.prog_len = len; bus1.start = 1'b1; end
    tick();
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if ((sel == 0 ? bus0.done : bus1.done) === 1'b1) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: dut%0d done never rose within 200 cycles", sel);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic load_chain();
    load_word(0, 32'h00430820);
    load_word(1, 32'h00262022);
    load_word(2, 32'h00243824);
    load_word(3, 32'h00E75025);
    load_word(4, 32'h0144802A);
  endtask

  task automatic check_end(input string tag, input int cyc_act, input int cyc_exp,
                           input int stall_exp, input int pc_exp);
    if (cyc_exp > 0) check({tag, "_cycles"}, 32'(cyc_act), 32'(cyc_exp));
    check({tag, "_done"},  32'(bus0.done), 32'd1);
    check({tag, "_stall"}, 32'(bus0.stall_cnt), 32'(stall_exp));
    check({tag, "_pc"},    32'(bus0.pc), 32'(pc_exp));
    check({tag, "_qempty"}, 32'(q0.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    bus0.load_en = 1'b0; bus0.load_addr = '0; bus0.load_data = '0; bus0.prog_len = '0; bus0.start = 1'b0;
    bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_data = '0; bus1.prog_len = '0; bus1.start = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_inst",   bus0.inst, NOP);
    check("rst_valid",  32'(bus0.inst_valid), 32'd0);
    check("rst_bubble", 32'(bus0.bubble), 32'd0);
    check("rst_pc",     32'(bus0.pc), 32'd0);
    check("rst_stall",  32'(bus0.stall_cnt), 32'd0);
    check("rst_done",   32'(bus0.done), 32'd0);

    // zero-length program goes straight to DONE without any issue slot
    start_run(0, '0);
    check("len0_done",  32'(bus0.done), 32'd1);
    check("len0_valid", 32'(bus0.inst_valid), 32'd0);
    repeat (3) tick();
    do_reset();

    // dependent chain
    load_chain();
    push_chain();
    start_run(0, 6'd5);
    wait_done(0, cyc);
    check_end("chain", cyc, CHAIN_CYC, CHAIN_STALL, 5);

    // reset in the 3rd RUN cycle
    push(0, 32'h00430820, 1'b0);
`ifdef FETCH_HAZARD_DETECT_EN
    push(0, NOP, 1'b1);
`else
    push(0, 32'h00262022, 1'b0);
`endif
    start_run(0, 6'd5);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_inst",   bus0.inst, NOP);
    check("midrst_valid",  32'(bus0.inst_valid), 32'd0);
    check("midrst_pc",     32'(bus0.pc), 32'd0);
    check("midrst_stall",  32'(bus0.stall_cnt), 32'd0);
    check("midrst_qempty", 32'(q0.size()), 32'd0);

    // restart with imem intact; writes during RUN must be dropped
    push_chain();
    start_run(0, 6'd5);
    bus0.load_en = 1'b1; bus0.load_addr = 5'd2; bus0.load_data = 32'hFFFFFFFF;
    tick(); tick(); tick();
    bus0.load_en = 1'b0;
    wait_done(0, cyc);
    check_end("restart", cyc, 0, CHAIN_STALL, 5);

    // writes in DONE are dropped too; rerun from DONE rereads the chain
    bus0.load_en = 1'b1; bus0.load_addr = 5'd0; bus0.load_data = 32'h00000000;
    tick();
    bus0.load_en = 1'b0;
    push_chain();
    start_run(0, 6'd5);
    wait_done(0, cyc);
    check_end("reread", cyc, CHAIN_CYC, CHAIN_STALL, 5);

    // independent program
    do_reset();
    load_word(0, 32'h00430820);
    load_word(1, 32'h00A63822);
    load_word(2, 32'h0109502A);
    push(0, 32'h00430820, 1'b0);
    push(0, 32'h00A63822, 1'b0);
    push(0, 32'h0109502A, 1'b0);
    repeat (4) push(0, NOP, 1'b1);
    start_run(0, 6'd3);
    wait_done(0, cyc);
    check_end("indep", cyc, 8, 0, 3);

    // NOP_GAP=2 instance
    do_reset();
    load_word(0, 32'h00430820);
    load_word(1, 32'h00262022);
    push(1, 32'h00430820, 1'b0);
`ifdef FETCH_HAZARD_DETECT_EN
    push(1, NOP, 1'b1);
    push(1, NOP, 1'b1);
`endif
    push(1, 32'h00262022, 1'b0);
    repeat (4) push(1, NOP, 1'b1);
    start_run(1, 6'd2);
    wait_done(1, cyc);
    check("gap2_done",   32'(bus1.done), 32'd1);
    check("gap2_stall",  32'(bus1.stall_cnt), 32'(GAP2_STALL));
    check("gap2_pc",     32'(bus1.pc), 32'd2);
    check("gap2_qempty", 32'(q1.size()), 32'd0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
